// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch block.
package fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC = '0;
    localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        STALL  = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order FIFO of {pc, instr} pairs between fetch and decode.
// Flush wins over push/pop in the same cycle.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic         full,
    output logic         empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    fetch_entry_t          mem_q [DEPTH];
    fetch_entry_t          mem_d [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    // Next pointer/occupancy/storage values; pointers wrap naturally (power-of-two depth).
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_entry;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only meaningful while counted as occupied.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/fetch_controller.sv
// Fetch stage: owns the PC, drives the instruction memory and feeds decode
// through a small queue with valid/ready, redirect flush and halt.
//
// state  | meaning
// FETCH  | issuing fetches
// STALL  | queue full and decode did not take the head
// HALTED | halt high, no fetches issued
module fetch_controller #(
    parameter int                       XLEN     = fetch_pkg::XLEN,
    parameter logic [XLEN-1:0]          RESET_PC = fetch_pkg::RESET_PC,
    parameter int                       QDEPTH   = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            halt,
    output logic            if_valid,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    input  logic            if_ready,
    output logic [XLEN-1:0] fetch_count
);

    import fetch_pkg::*;

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] count_q, count_d;
    fetch_entry_t    hold_q, hold_d;

    fetch_entry_t    q_head;
    fetch_entry_t    q_push_entry;
    logic            q_full;
    logic            q_empty;
    logic            deq;
    logic            push;

    assign imem_addr    = pc_q;
    assign fetch_count  = count_q;
    assign q_push_entry = '{pc: pc_q, instr: imem_data};

    // Decode sees the queue head; while empty it keeps seeing the last head shown.
    assign if_valid = !q_empty;
    assign if_pc    = q_empty ? hold_q.pc    : q_head.pc;
    assign if_instr = q_empty ? hold_q.instr : q_head.instr;

    fetch_queue #(
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_entry (q_push_entry),
        .pop        (deq),
        .flush      (redirect_valid),
        .head       (q_head),
        .full       (q_full),
        .empty      (q_empty)
    );

    // Handshake, next state, PC and counter updates.
    always_comb begin
        deq     = !q_empty && if_ready;
        push    = !redirect_valid && !halt && (!q_full || deq);
        state_d = FETCH;
        pc_d    = pc_q;
        count_d = count_q;
        hold_d  = q_empty ? hold_q : q_head;

        if (redirect_valid) begin
            state_d = halt ? HALTED : FETCH;
        end else if (halt) begin
            state_d = HALTED;
        end else if (q_full && !deq) begin
            state_d = STALL;
        end

        if (redirect_valid) begin
            pc_d = {redirect_pc[XLEN-1:2], 2'b00};
        end else if (push) begin
            pc_d = pc_q + XLEN'(PC_STEP);
        end

        if (push) begin
            count_d = count_q + XLEN'(1);
        end
    end

    // Stage registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            count_q <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
            hold_q  <= hold_d;
        end
    end

endmodule
